// File: rtl/regfile_write_ctrl_pkg.sv
// Shared definitions for the register-file write controller: FSM encoding and source indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_write_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int SRC0 = 0;
  localparam int SRC1 = 1;

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Bundles both write-request sources and the RAM write port of regfile_write_ctrl.
// Latency: n/a (wiring only).
// Backpressure: oWrReady0/oWrReady1 qualify iWrValid0/iWrValid1 (valid/ready handshake).
// Ports: iWr{Valid,Addr,Data}{0,1} requests, oWrReady{0,1} accepts,
//        oRamEn/oRamWe/oRamAddr/oRamData RAM write port, oInitDone contents-valid flag.
// master = requester/RAM side, slave = controller side.
interface regfile_write_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  iWrValid0;
  logic [ADDR_WIDTH-1:0] iWrAddr0;
  logic [DATA_WIDTH-1:0] iWrData0;
  logic                  oWrReady0;
  logic                  iWrValid1;
  logic [ADDR_WIDTH-1:0] iWrAddr1;
  logic [DATA_WIDTH-1:0] iWrData1;
  logic                  oWrReady1;
  logic                  oRamEn;
  logic                  oRamWe;
  logic [ADDR_WIDTH-1:0] oRamAddr;
  logic [DATA_WIDTH-1:0] oRamData;
  logic                  oInitDone;

  modport master (
    output iWrValid0, iWrAddr0, iWrData0, iWrValid1, iWrAddr1, iWrData1,
    input  oWrReady0, oWrReady1, oRamEn, oRamWe, oRamAddr, oRamData, oInitDone
  );

  modport slave (
    input  iWrValid0, iWrAddr0, iWrData0, iWrValid1, iWrAddr1, iWrData1,
    output oWrReady0, oWrReady1, oRamEn, oRamWe, oRamAddr, oRamData, oInitDone
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; one-hot grant, pointer remembers the last granted source.
// Latency: grant is combinational from iValid and the pointer; pointer updates on the granting edge.
// Backpressure: a grant is a transfer, so the pointer only moves when a source is accepted.
// Ports: iClk, iRst (async, active-high), iValid[1:0] request vector, oGrant[1:0] one-hot grant.
module rr_arb2
  import regfile_write_ctrl_pkg::*;
(
  input  logic       iClk,
  input  logic       iRst,
  input  logic [1:0] iValid,
  output logic [1:0] oGrant
);

  // Source granted most recently. Reset value SRC1 makes source 0 win the first tie.
  logic lastGnt;

  always_comb begin
    oGrant = 2'b00;
    case (iValid)
      2'b01:   oGrant = 2'b01;
      2'b10:   oGrant = 2'b10;
      2'b11:   oGrant = (lastGnt == 1'(SRC0)) ? 2'b10 : 2'b01;
      default: oGrant = 2'b00;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      lastGnt <= 1'(SRC1);
    end else if (oGrant[SRC1]) begin
      lastGnt <= 1'(SRC1);
    end else if (oGrant[SRC0]) begin
      lastGnt <= 1'(SRC0);
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Arbitrates two write sources onto one RAM write port; optional power-up clear (macro REGFILE_CLEAR_EN).
// Latency: 1 cycle from accepted request to registered RAM strobe; one write per cycle.
// Backpressure: readies are combinational from valids + round-robin pointer, held low during clear and reset.
// Ports: iClk, iRst (async, active-high), bus (regfile_write_ctrl_if.slave: requests, readies, RAM port, oInitDone).
module regfile_write_ctrl
  import regfile_write_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                 iClk,
  input  logic                 iRst,
  regfile_write_ctrl_if.slave  bus
);

  logic                  runMode;
  logic                  clearStep;
  logic [ADDR_WIDTH-1:0] clearAddr;
  logic [1:0]            reqValid;
  logic [1:0]            grant;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selData;
  logic                  selWrite;
  logic                  ramEn;
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic [DATA_WIDTH-1:0] ramData;

`ifdef REGFILE_CLEAR_EN
  state_t              state;
  state_t              stateNext;
  // One extra bit: the top bit marks "last address already issued", which
  // gives exactly 2**ADDR_WIDTH clear strobes before switching to RUN.
  logic [ADDR_WIDTH:0] clrCnt;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= ST_CLEAR;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_CLEAR: if (clrCnt[ADDR_WIDTH]) stateNext = ST_RUN;
      ST_RUN:   stateNext = ST_RUN;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      clrCnt <= '0;
    end else if (state == ST_CLEAR && !clrCnt[ADDR_WIDTH]) begin
      clrCnt <= clrCnt + 1'b1;
    end
  end

  always_comb begin
    runMode   = (state == ST_RUN);
    clearStep = (state == ST_CLEAR) && !clrCnt[ADDR_WIDTH];
    clearAddr = clrCnt[ADDR_WIDTH-1:0];
  end
`else
  assign runMode   = 1'b1;
  assign clearStep = 1'b0;
  assign clearAddr = '0;
`endif

  // Readies are forced low while reset is asserted, not only after the next edge.
  assign reqValid = {bus.iWrValid1, bus.iWrValid0} & {2{runMode & ~iRst}};

  rr_arb2 u_arb (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (reqValid),
    .oGrant (grant)
  );

  assign bus.oWrReady0 = grant[SRC0];
  assign bus.oWrReady1 = grant[SRC1];

  assign selAddr  = grant[SRC1] ? bus.iWrAddr1 : bus.iWrAddr0;
  assign selData  = grant[SRC1] ? bus.iWrData1 : bus.iWrData0;
  // Writes to register 0 are acknowledged but never reach the RAM.
  assign selWrite = (|grant) && !((ZERO_REG != 0) && (selAddr == '0));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ramEn   <= 1'b0;
      ramAddr <= '0;
      ramData <= '0;
    end else if (clearStep) begin
      ramEn   <= 1'b1;
      ramAddr <= clearAddr;
      ramData <= '0;
    end else begin
      ramEn <= selWrite;
      if (selWrite) begin
        ramAddr <= selAddr;
        ramData <= selData;
      end
    end
  end

  assign bus.oRamEn    = ramEn;
  assign bus.oRamWe    = ramEn;
  assign bus.oRamAddr  = ramAddr;
  assign bus.oRamData  = ramData;
  assign bus.oInitDone = runMode;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Self-checking bench for regfile_write_ctrl (ADDR_WIDTH=5, DATA_WIDTH=32, ZERO_REG=1).
// Latency expectations: readies checked in-cycle, RAM strobe checked one edge after acceptance.
// Backpressure: readies checked against round-robin order; clear phase expects readies low.
module tb_regfile_write_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGFILE_CLEAR_EN
  localparam logic CLR_ON = 1'b1;
`else
  localparam logic CLR_ON = 1'b0;
`endif

  logic iClk;
  logic iRst;
  int   checks;
  int   errors;

  regfile_write_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0;
    logic          r1;
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkVec(logic v0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                 logic v1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                                 logic r0, logic r1, logic en,
                                 logic [AW-1:0] addr, logic [DW-1:0] data);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.en = en; v.addr = addr; v.data = data;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setReq(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.iWrValid0 = v0; bus.iWrAddr0 = a0; bus.iWrData0 = d0;
    bus.iWrValid1 = v1; bus.iWrAddr1 = a1; bus.iWrData1 = d1;
  endtask

  // Entered right after reset release (before the first clock edge of the clear).
  task automatic runClear();
    bus.iWrValid0 = 1'b1;
    bus.iWrValid1 = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(posedge iClk); #1;
      check($sformatf("clear%0d_en", c), {63'd0, bus.oRamEn}, 64'd1);
      check($sformatf("clear%0d_we", c), {63'd0, bus.oRamWe}, 64'd1);
      check($sformatf("clear%0d_addr", c), {59'd0, bus.oRamAddr}, 64'(c));
      check($sformatf("clear%0d_data", c), {32'd0, bus.oRamData}, 64'd0);
      check($sformatf("clear%0d_done", c), {63'd0, bus.oInitDone}, 64'd0);
      check($sformatf("clear%0d_rdy", c), {62'd0, bus.oWrReady1, bus.oWrReady0}, 64'd0);
    end
    bus.iWrValid0 = 1'b0;
    bus.iWrValid1 = 1'b0;
    @(posedge iClk); #1;
    check("clear_done_rise", {63'd0, bus.oInitDone}, 64'd1);
    check("clear_done_en", {63'd0, bus.oRamEn}, 64'd0);
  endtask

  initial begin
    logic found;
    checks = 0;
    errors = 0;

    vecs[0]  = mkVec(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 1, 0, 1, 5'd1, 32'h11111111);
    vecs[1]  = mkVec(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 0, 1, 1, 5'd2, 32'h22222222);
    vecs[2]  = mkVec(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 1, 0, 1, 5'd1, 32'h11111111);
    vecs[3]  = mkVec(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 0, 1, 1, 5'd2, 32'h22222222);
    vecs[4]  = mkVec(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 0, 5'd2, 32'h22222222);
    vecs[5]  = mkVec(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        1, 0, 1, 5'd5, 32'hDEADBEEF);
    vecs[6]  = mkVec(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 0, 5'd5, 32'hDEADBEEF);
    vecs[7]  = mkVec(0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFFFFFF, 0, 1, 0, 5'd5, 32'hDEADBEEF);
    vecs[8]  = mkVec(1, 5'd7, 32'h70707070, 1, 5'd8, 32'h80808080, 1, 0, 1, 5'd7, 32'h70707070);
    vecs[9]  = mkVec(0, 5'd0, 32'h0,        1, 5'd9, 32'h90909090, 0, 1, 1, 5'd9, 32'h90909090);
    vecs[10] = mkVec(0, 5'd0, 32'h0,        1, 5'd10, 32'hA0A0A0A0, 0, 1, 1, 5'd10, 32'hA0A0A0A0);
    vecs[11] = mkVec(1, 5'd3, 32'h33333333, 0, 5'd0, 32'h0,        1, 0, 1, 5'd3, 32'h33333333);
    vecs[12] = mkVec(1, 5'd0, 32'h12345678, 0, 5'd0, 32'h0,        1, 0, 0, 5'd3, 32'h33333333);
    vecs[13] = mkVec(1, 5'd4, 32'h44444444, 1, 5'd6, 32'h66666666, 0, 1, 1, 5'd6, 32'h66666666);
    vecs[14] = mkVec(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 0, 5'd6, 32'h66666666);

    // Reset state, with a valid pending to show readies are gated by reset.
    iRst = 1'b1;
    setReq(1, 5'd4, 32'h1, 1, 5'd6, 32'h2);
    repeat (3) @(posedge iClk);
    #1;
    check("rst_en", {63'd0, bus.oRamEn}, 64'd0);
    check("rst_we", {63'd0, bus.oRamWe}, 64'd0);
    check("rst_addr", {59'd0, bus.oRamAddr}, 64'd0);
    check("rst_data", {32'd0, bus.oRamData}, 64'd0);
    check("rst_rdy", {62'd0, bus.oWrReady1, bus.oWrReady0}, 64'd0);
    check("rst_done", {63'd0, bus.oInitDone}, {63'd0, ~CLR_ON});
    setReq(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    iRst = 1'b0;
    #1;
    check("release_done", {63'd0, bus.oInitDone}, {63'd0, ~CLR_ON});
    check("release_en", {63'd0, bus.oRamEn}, 64'd0);
`ifdef REGFILE_CLEAR_EN
    runClear();
`endif

    // Table-driven run phase: one vector per cycle, back to back.
    for (int i = 0; i < 15; i++) begin
      setReq(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      #1;
      check($sformatf("vec%0d_rdy0", i), {63'd0, bus.oWrReady0}, {63'd0, vecs[i].r0});
      check($sformatf("vec%0d_rdy1", i), {63'd0, bus.oWrReady1}, {63'd0, vecs[i].r1});
      @(posedge iClk); #1;
      check($sformatf("vec%0d_en", i), {63'd0, bus.oRamEn}, {63'd0, vecs[i].en});
      check($sformatf("vec%0d_we", i), {63'd0, bus.oRamWe}, {63'd0, vecs[i].en});
      check($sformatf("vec%0d_addr", i), {59'd0, bus.oRamAddr}, {59'd0, vecs[i].addr});
      check($sformatf("vec%0d_data", i), {32'd0, bus.oRamData}, {32'd0, vecs[i].data});
    end

    // Reset asserted in the middle of a transfer.
    setReq(1, 5'd9, 32'h99999999, 0, 5'd0, 32'h0);
    #1;
    check("midxfer_rdy0", {63'd0, bus.oWrReady0}, 64'd1);
    @(posedge iClk); #1;
    check("midxfer_en", {63'd0, bus.oRamEn}, 64'd1);
    iRst = 1'b1;
    #1;
    check("midxfer_rst_en", {63'd0, bus.oRamEn}, 64'd0);
    check("midxfer_rst_addr", {59'd0, bus.oRamAddr}, 64'd0);
    check("midxfer_rst_data", {32'd0, bus.oRamData}, 64'd0);
    check("midxfer_rst_rdy", {63'd0, bus.oWrReady0}, 64'd0);
    check("midxfer_rst_done", {63'd0, bus.oInitDone}, {63'd0, ~CLR_ON});
    setReq(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(posedge iClk); #1;
    iRst = 1'b0;

`ifdef REGFILE_CLEAR_EN
    // Reset at clear address 17, then the clear must restart from 0.
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge iClk); #1;
      if (bus.oRamEn && bus.oRamAddr == 5'd17) begin
        found = 1'b1;
        break;
      end
    end
    check("midclear_reach17", {63'd0, found}, 64'd1);
    iRst = 1'b1;
    #1;
    check("midclear_rst_en", {63'd0, bus.oRamEn}, 64'd0);
    check("midclear_rst_addr", {59'd0, bus.oRamAddr}, 64'd0);
    check("midclear_rst_done", {63'd0, bus.oInitDone}, 64'd0);
    @(posedge iClk); #1;
    iRst = 1'b0;
    runClear();
`else
    found = 1'b1;
    check("off_done_after_rst", {63'd0, bus.oInitDone & found}, 64'd1);
    setReq(1, 5'd3, 32'h0BADF00D, 0, 5'd0, 32'h0);
    #1;
    check("off_rdy0", {63'd0, bus.oWrReady0}, 64'd1);
    @(posedge iClk); #1;
    setReq(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("off_wr_en", {63'd0, bus.oRamEn}, 64'd1);
    check("off_wr_addr", {59'd0, bus.oRamAddr}, 64'd3);
    check("off_wr_data", {32'd0, bus.oRamData}, 64'h0BADF00D);
    @(posedge iClk); #1;
    check("off_idle_en", {63'd0, bus.oRamEn}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_ctrl.md
REGFILE_WRITE_CTRL -- requirements
Module: regfile_write_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the RAM word and write data.
REQ-002 Parameter ADDR_WIDTH, default 5, RAM address width; depth = 2**ADDR_WIDTH.
REQ-003 Parameter ZERO_REG, default 1, when 1 writes to address 0 are accepted and discarded.
REQ-004 iClk  input  1  single clock; all state on rising edge.
REQ-005 iRst  input  1  reset, asynchronous, active-high.
REQ-006 iWrValid0 / iWrAddr0 / iWrData0  input  1 / ADDR_WIDTH / DATA_WIDTH  write request, source 0.
REQ-007 oWrReady0  output  1  source 0 request accepted this cycle.
REQ-008 iWrValid1 / iWrAddr1 / iWrData1  input  1 / ADDR_WIDTH / DATA_WIDTH  write request, source 1.
REQ-009 oWrReady1  output  1  source 1 request accepted this cycle.
REQ-010 oRamEn / oRamWe  output  1 / 1  registered enable and write strobe to one dual-port RAM write port.
REQ-011 oRamAddr / oRamData  output  ADDR_WIDTH / DATA_WIDTH  registered RAM address and write data.
REQ-012 oInitDone  output  1  high once the RAM contents are valid; stays high until the next reset.

Function
REQ-013 FSM states: CLEAR, RUN. Reset enters CLEAR when REGFILE_CLEAR_EN is defined, otherwise RUN.
REQ-014 CLEAR: counter walks 0..2**ADDR_WIDTH-1, one address per cycle. Each step drives oRamEn=1, oRamWe=1, oRamAddr=counter, oRamData=0. oWrReady0/1=0 throughout.
REQ-015 CLEAR -> RUN on the cycle after the last address is issued. oInitDone rises in that same cycle. Clear duration is exactly 2**ADDR_WIDTH cycles.
REQ-016 RUN: a transfer occurs on a source when its valid and ready are both high at a rising edge.
REQ-017 oWrReadyN is combinational from the valids and the last-grant pointer. At most one ready is high per cycle. Ready is never high without its valid.
REQ-018 Arbitration is round-robin. One valid source gets the grant. With both valid, the grant goes to the source not granted last. The pointer updates only on a transfer. The pointer resets to favour source 0.
REQ-019 Latency is 1 cycle: a transfer at edge k drives oRamEn=oRamWe=1 with the captured addr/data during cycle k+1.
REQ-020 With no transfer, oRamEn=oRamWe=0 in the next cycle and oRamAddr/oRamData hold their values.
REQ-021 ZERO_REG=1 and address 0: the request is acknowledged (ready high) but oRamEn/oRamWe stay 0. Arbitration still counts it as a grant.
REQ-022 Throughput is one write per cycle. A source held valid with no competitor transfers every cycle.

Reset
REQ-023 iRst asserted at any time, including mid-CLEAR or mid-transfer, immediately forces: state = reset entry state, counter=0, grant pointer=source 0, oRamEn=0, oRamWe=0, oRamAddr=0, oRamData=0, oWrReady0/1=0.
REQ-024 oInitDone resets to 0 with REGFILE_CLEAR_EN defined and to 1 without it. A clear interrupted by reset restarts from address 0.

Configuration
REQ-025 Macro REGFILE_CLEAR_EN defined: the CLEAR state and address counter are compiled in, per REQ-014/015.
REQ-026 Macro REGFILE_CLEAR_EN undefined: no CLEAR state or counter logic exists. The block is in RUN from reset release, and RAM contents are undefined until written.

Structure
REQ-027 A shared package holds the FSM state encoding (ST_CLEAR, ST_RUN) and the source index constants (SRC0=0, SRC1=1).
REQ-028 One sub-module, rr_arb2, holds the 2-input round-robin arbiter: valids plus pointer in, one-hot grant out, pointer update on transfer. FSM, counter and output registers stay in regfile_write_ctrl.

Verification
REQ-029 Clear: ADDR_WIDTH=5, macro on, release reset.
  - Cycles 0..31 show En=We=1, Addr 0..31, Data 0.
  - oInitDone=1 at cycle 32; readies low before that.
REQ-030 Single write: RUN, iWrValid0=1, Addr=5, Data=0xDEADBEEF for one cycle.
  - oWrReady0=1 that cycle.
  - Next cycle En=We=1, Addr=5, Data=0xDEADBEEF; following cycle En=We=0.
REQ-031 Contention: both valid for 4 cycles, Addr0=1, Addr1=2.
  - Grants are 0,1,0,1.
  - RAM writes are Addr 1,2,1,2 on cycles +1..+4.
REQ-032 Zero register: ZERO_REG=1, source 1 writes Addr=0, Data=0xFFFFFFFF.
  - oWrReady1=1.
  - Next cycle oRamWe=0.
  - Next contention cycle grants source 0.
REQ-033 Reset mid-clear: assert iRst at clear address 17 for 1 cycle.
  - Outputs go to 0 asynchronously.
  - After release, clear restarts at Addr 0 and finishes 32 cycles later.
REQ-034 Macro off: release reset.
  - oInitDone=1 immediately.
  - Source 0 write to Addr 3 appears at the RAM one cycle later.
